// File: rtl/ram_arb_pkg.sv
// Shared types for the RAM arbiter: return-owner tag and RAM read latency.
package ram_arb_pkg;
  typedef enum logic [1:0] {OWN_NONE, OWN_VID, OWN_CPU} owner_t;
  localparam int RAM_LAT = 1;
endpackage

// File: rtl/ram_arb_ret.sv
// Owner tag pipeline that tracks each accepted access through the RAM and
// steers the returned data to the owning requester's q/rv.
module ram_arb_ret
  import ram_arb_pkg::*;
#(
  parameter int RAM_LAT = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  owner_t     tag,
  input  logic [7:0] ram_q,
  output logic [7:0] vid_q,
  output logic       vid_rv,
  output logic [7:0] cpu_q,
  output logic       cpu_rv
);

  // tag_pipe[0] is loaded at the accept edge; tag_pipe[RAM_LAT] lines up with ram_q
  owner_t tag_pipe [RAM_LAT:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i <= RAM_LAT; i++) tag_pipe[i] <= OWN_NONE;
      vid_q  <= '0;
      vid_rv <= 1'b0;
      cpu_q  <= '0;
      cpu_rv <= 1'b0;
    end else begin
      tag_pipe[0] <= tag;
      for (int i = 1; i <= RAM_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
      vid_rv <= (tag_pipe[RAM_LAT] == OWN_VID);
      cpu_rv <= (tag_pipe[RAM_LAT] == OWN_CPU);
      if (tag_pipe[RAM_LAT] == OWN_VID) vid_q <= ram_q;
      if (tag_pipe[RAM_LAT] == OWN_CPU) cpu_q <= ram_q;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Single-port RAM arbiter: video reads have priority over CPU accesses.
// Define RAMARB_STARVE_GUARD_EN to force a CPU grant after STARVE denied cycles.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter  int KB     = 64,
  parameter  int STARVE = 4,
  localparam int AW     = $clog2(KB*1024)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_a,
  output logic          vid_gnt,
  output logic [7:0]    vid_q,
  output logic          vid_rv,
  input  logic          cpu_req,
  input  logic [AW-1:0] cpu_a,
  input  logic [7:0]    cpu_d,
  input  logic          cpu_w,
  output logic          cpu_gnt,
  output logic [7:0]    cpu_q,
  output logic          cpu_rv,
  output logic [AW-1:0] ram_a,
  output logic [7:0]    ram_d,
  output logic          ram_w,
  input  logic [7:0]    ram_q
);

  logic   force_cpu;
  owner_t win;
  logic   ram_w_r;

`ifdef RAMARB_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE+1);
  logic [CW-1:0] starve_cnt;

  always_ff @(posedge clock) begin
    if (reset || !cpu_req || cpu_gnt)           starve_cnt <= '0;
    else if (starve_cnt != STARVE[CW-1:0])      starve_cnt <= starve_cnt + 1'b1;
  end

  assign force_cpu = cpu_req && (starve_cnt == STARVE[CW-1:0]);
`else
  // strict priority: never forced (STARVE referenced only to keep it live)
  assign force_cpu = (STARVE < 0);
`endif

  assign vid_gnt = !reset && vid_req && !force_cpu;
  assign cpu_gnt = !reset && cpu_req && (!vid_req || force_cpu);

  always_comb begin
    win = OWN_NONE;
    if (vid_gnt)      win = OWN_VID;
    else if (cpu_gnt) win = OWN_CPU;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ram_a   <= '0;
      ram_d   <= '0;
      ram_w_r <= 1'b0;
    end else begin
      case (win)
        OWN_VID: begin
          ram_a   <= vid_a;
          ram_w_r <= 1'b0;
        end
        OWN_CPU: begin
          ram_a   <= cpu_a;
          ram_d   <= cpu_d;
          ram_w_r <= cpu_w;
        end
        default: ram_w_r <= 1'b0;
      endcase
    end
  end

  // Reset cancels a write still waiting for the RAM edge it would land on.
  assign ram_w = ram_w_r && !reset;

  ram_arb_ret #(.RAM_LAT(RAM_LAT)) u_ret (
    .clock  (clock),
    .reset  (reset),
    .tag    (win),
    .ram_q  (ram_q),
    .vid_q  (vid_q),
    .vid_rv (vid_rv),
    .cpu_q  (cpu_q),
    .cpu_rv (cpu_rv)
  );

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: behavioural write-first RAM, reference memory and an
// in-order scoreboard of expected returns, plus per-scenario inline checks.
module tb_ram_arbiter;
  import ram_arb_pkg::*;

  localparam int KB     = 64;
  localparam int STARVE = 4;
  localparam int AW     = 16;

  logic          clock = 1'b0;
  logic          reset;
  logic          vid_req, cpu_req, cpu_w;
  logic [AW-1:0] vid_a, cpu_a;
  logic [7:0]    cpu_d;
  logic          vid_gnt, cpu_gnt, vid_rv, cpu_rv;
  logic [7:0]    vid_q, cpu_q;
  logic [AW-1:0] ram_a;
  logic [7:0]    ram_d, ram_q;
  logic          ram_w;

  typedef struct {
    owner_t     own;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc    = 0;
  logic [7:0] ram_mem [int];
  logic [7:0] ref_mem [int];
  logic       pend_w = 1'b0;
  int         pend_a;
  logic [7:0] pend_d;
  int         ra;

  ram_arbiter #(.KB(KB), .STARVE(STARVE)) dut (
    .clock(clock), .reset(reset),
    .vid_req(vid_req), .vid_a(vid_a), .vid_gnt(vid_gnt), .vid_q(vid_q), .vid_rv(vid_rv),
    .cpu_req(cpu_req), .cpu_a(cpu_a), .cpu_d(cpu_d), .cpu_w(cpu_w),
    .cpu_gnt(cpu_gnt), .cpu_q(cpu_q), .cpu_rv(cpu_rv),
    .ram_a(ram_a), .ram_d(ram_d), .ram_w(ram_w), .ram_q(ram_q)
  );

  always #5 clock = ~clock;

  // power-up RAM contents: distinct, address-derived
  function automatic logic [7:0] pat(input int a);
    return 8'(a) ^ 8'(a >> 8);
  endfunction

  // write-first synchronous RAM
  initial begin
    ram_q = '0;
    forever begin
      @(posedge clock);
      ra = int'(ram_a);
      ram_q <= ram_w ? ram_d : (ram_mem.exists(ra) ? ram_mem[ra] : pat(ra));
      if (ram_w) ram_mem[ra] = ram_d;
    end
  end

  // record every accepted transfer with its expected return
  initial begin
    exp_t e;
    int   a;
    forever begin
      @(posedge clock);
      cyc++;
      if (reset) begin
        sb.delete();
        pend_w = 1'b0;
      end else begin
        if (pend_w) ref_mem[pend_a] = pend_d;
        pend_w = 1'b0;
        if (vid_req && vid_gnt) begin
          a = int'(vid_a);
          e.own = OWN_VID; e.cyc = cyc;
          e.data = ref_mem.exists(a) ? ref_mem[a] : pat(a);
          sb.push_back(e);
        end
        if (cpu_req && cpu_gnt) begin
          a = int'(cpu_a);
          e.own = OWN_CPU; e.cyc = cyc;
          e.data = cpu_w ? cpu_d : (ref_mem.exists(a) ? ref_mem[a] : pat(a));
          sb.push_back(e);
          if (cpu_w) begin
            pend_w = 1'b1; pend_a = a; pend_d = cpu_d;
          end
        end
      end
    end
  end

  // compare every return against the head of the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (vid_rv && cpu_rv) begin
        checks++; errors++;
        $display("FAIL both_rv: vid_rv=%0b cpu_rv=%0b, required not both", vid_rv, cpu_rv);
      end
      if (vid_rv || cpu_rv) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL spurious_rv: vid_rv=%0b cpu_rv=%0b with nothing outstanding", vid_rv, cpu_rv);
        end else begin
          e = sb.pop_front();
          if ((e.own == OWN_VID) !== vid_rv || (e.own == OWN_CPU) !== cpu_rv ||
              (vid_rv ? vid_q : cpu_q) !== e.data || (cyc - e.cyc) != 2) begin
            errors++;
            $display("FAIL return: vid_rv=%0b cpu_rv=%0b q=%02h lat=%0d, required owner=%s q=%02h lat=2",
                     vid_rv, cpu_rv, vid_rv ? vid_q : cpu_q, cyc - e.cyc, e.own.name(), e.data);
          end
        end
      end
    end
  end

  task automatic test_reset();
    reset = 1'b1; vid_req = 1'b1; cpu_req = 1'b1;
    vid_a = 16'h1111; cpu_a = 16'h2222; cpu_d = 8'h33; cpu_w = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if ({vid_gnt, cpu_gnt} !== 2'b00) begin
      errors++; $display("FAIL reset_gnt: got %b, required 00", {vid_gnt, cpu_gnt});
    end
    checks++;
    if (ram_a !== '0 || ram_d !== '0 || ram_w !== 1'b0) begin
      errors++; $display("FAIL reset_ram: a=%h d=%h w=%b, required 0/0/0", ram_a, ram_d, ram_w);
    end
    checks++;
    if (vid_q !== 8'h00 || cpu_q !== 8'h00 || vid_rv !== 1'b0 || cpu_rv !== 1'b0) begin
      errors++; $display("FAIL reset_ret: vq=%h cq=%h vrv=%b crv=%b, required zeros", vid_q, cpu_q, vid_rv, cpu_rv);
    end
    vid_req = 1'b0; cpu_req = 1'b0; cpu_w = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_cpu_rw();
    @(negedge clock);
    cpu_req = 1'b1; cpu_w = 1'b1; cpu_a = 16'h0100; cpu_d = 8'h5A;
    #1;
    checks++;
    if (cpu_gnt !== 1'b1) begin
      errors++; $display("FAIL cpu_gnt_idle: got %b, required 1", cpu_gnt);
    end
    @(negedge clock);
    cpu_w = 1'b0;
    @(negedge clock);
    cpu_req = 1'b0;
    checks++;
    if (cpu_rv !== 1'b0) begin
      errors++; $display("FAIL cpu_rv_early: got %b, required 0", cpu_rv);
    end
    @(negedge clock);
    checks++;
    if (cpu_rv !== 1'b1 || cpu_q !== 8'h5A) begin
      errors++; $display("FAIL cpu_write_ret: rv=%b q=%h, required 1/5a", cpu_rv, cpu_q);
    end
    @(negedge clock);
    checks++;
    if (cpu_rv !== 1'b1 || cpu_q !== 8'h5A) begin
      errors++; $display("FAIL cpu_read_ret: rv=%b q=%h, required 1/5a", cpu_rv, cpu_q);
    end
    @(negedge clock);
    checks++;
    if (cpu_rv !== 1'b0) begin
      errors++; $display("FAIL cpu_rv_pulse: got %b, required 0", cpu_rv);
    end
  endtask

  task automatic test_priority();
    @(negedge clock);
    vid_req = 1'b1; vid_a = 16'h1000;
    cpu_req = 1'b1; cpu_w = 1'b0; cpu_a = 16'h0300;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (vid_gnt !== 1'b1 || cpu_gnt !== 1'b0) begin
        errors++; $display("FAIL priority_%0d: vid_gnt=%b cpu_gnt=%b, required 1/0", i, vid_gnt, cpu_gnt);
      end
      @(negedge clock);
    end
    vid_req = 1'b0;
    #1;
    checks++;
    if (cpu_gnt !== 1'b1 || vid_gnt !== 1'b0) begin
      errors++; $display("FAIL priority_cpu4: vid_gnt=%b cpu_gnt=%b, required 0/1", vid_gnt, cpu_gnt);
    end
    @(negedge clock);
    cpu_req = 1'b0;
    repeat (4) @(negedge clock);
  endtask

  task automatic test_back_to_back();
    int run = 0, total = 0;
    bit done = 0;
    for (int i = 0; i < 13; i++) begin
      @(negedge clock);
      if (vid_rv) begin
        total++;
        if (!done) run++;
      end else if (run > 0) done = 1;
      vid_req = (i < 8);
      vid_a   = 16'h4000 + 16'(i);
    end
    vid_req = 1'b0;
    checks++;
    if (run != 8 || total != 8) begin
      errors++; $display("FAIL stream_run: run=%0d total=%0d, required 8/8", run, total);
    end
    repeat (3) @(negedge clock);
  endtask

  task automatic test_starve();
    bit exp_g;
    @(negedge clock);
    vid_req = 1'b1; vid_a = 16'h1234;
    cpu_req = 1'b1; cpu_w = 1'b0; cpu_a = 16'h0040;
    for (int i = 0; i < 25; i++) begin
      #1;
`ifdef RAMARB_STARVE_GUARD_EN
      exp_g = ((i % (STARVE + 1)) == STARVE);
`else
      exp_g = 1'b0;
`endif
      checks++;
      if (cpu_gnt !== exp_g || vid_gnt !== !exp_g) begin
        errors++; $display("FAIL starve_%0d: cpu_gnt=%b vid_gnt=%b, required %b/%b", i, cpu_gnt, vid_gnt, exp_g, !exp_g);
      end
      @(negedge clock);
    end
    vid_req = 1'b0; cpu_req = 1'b0;
    repeat (4) @(negedge clock);
  endtask

  task automatic test_raw();
    @(negedge clock);
    cpu_req = 1'b1; cpu_w = 1'b1; cpu_a = 16'h0200; cpu_d = 8'hA5;
    @(negedge clock);
    cpu_req = 1'b0; cpu_w = 1'b0;
    vid_req = 1'b1; vid_a = 16'h0200;
    @(negedge clock);
    vid_req = 1'b0;
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (vid_rv !== 1'b1 || vid_q !== 8'hA5) begin
      errors++; $display("FAIL raw_vid: rv=%b q=%h, required 1/a5", vid_rv, vid_q);
    end
    repeat (2) @(negedge clock);
  endtask

  task automatic test_reset_mid();
    @(negedge clock);
    cpu_req = 1'b1; cpu_w = 1'b1; cpu_a = 16'h0500; cpu_d = 8'hEE;
    @(negedge clock);
    cpu_req = 1'b0; cpu_w = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #1;
    checks++;
    if (ram_w !== 1'b0 || cpu_rv !== 1'b0) begin
      errors++; $display("FAIL rst_mid_w: ram_w=%b cpu_rv=%b, required 0/0", ram_w, cpu_rv);
    end
    checks++;
    if ((ram_mem.exists(32'h500) ? ram_mem[32'h500] : pat(32'h500)) !== 8'h05) begin
      errors++; $display("FAIL rst_mid_mem: ram[0500]=%h, required 05", ram_mem[32'h500]);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks++;
      if (cpu_rv !== 1'b0) begin
        errors++; $display("FAIL rst_mid_rv_%0d: cpu_rv=%b, required 0", i, cpu_rv);
      end
    end
    cpu_req = 1'b1; cpu_a = 16'h0500;
    @(negedge clock);
    cpu_req = 1'b0;
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (cpu_rv !== 1'b1 || cpu_q !== 8'h05) begin
      errors++; $display("FAIL rst_mid_read: rv=%b q=%h, required 1/05", cpu_rv, cpu_q);
    end
    repeat (2) @(negedge clock);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; vid_req = 1'b0; cpu_req = 1'b0; cpu_w = 1'b0;
    vid_a = '0; cpu_a = '0; cpu_d = '0;
    test_reset();
    test_cpu_rw();
    test_priority();
    test_back_to_back();
    test_starve();
    test_raw();
    test_reset_mid();
    repeat (4) @(negedge clock);
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL drain: %0d returns outstanding, required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
